// File: rtl/seq_approx_mul_if.sv
// seq_approx_mul_if: operand/result valid-ready handshake bundle for seq_approx_mul
interface seq_approx_mul_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_approx;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [CNT_W-1:0]   out_cycles;
  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_prod, out_cycles
  );
  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_prod, out_cycles
  );
endinterface

// File: rtl/seq_approx_mul.sv
// seq_approx_mul: iterative shift-and-add multiplier with optional low-column truncation and early exit
module seq_approx_mul #(
  parameter int WIDTH      = 4,
  parameter int TRUNC_COLS = 2,
  parameter int EARLY_EXIT = 1,
  parameter int CNT_W      = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  seq_approx_mul_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, b_sh;
  logic             approx_q, approx_d, valid_q, valid_d;
  logic [PW-1:0]    acc_q, acc_d, mask, pp;
  logic [CNT_W-1:0] k_q, k_d, cycles_q, cycles_d;
  logic             accept, busy, last;
  assign accept = state_q == IDLE && io.in_valid;
  assign busy   = state_q == BUSY;
  assign b_sh   = b_q >> k_q;
  assign mask   = approx_q ? {PW{1'b1}} << TRUNC_COLS : {PW{1'b1}};
  assign pp     = b_sh[0] ? ({{WIDTH{1'b0}}, a_q} << k_q) & mask : '0;
  assign last   = k_q == K_LAST || (EARLY_EXIT != 0 && b_sh[WIDTH-1:1] == '0);
  assign io.in_ready   = rst_n && state_q == IDLE;
  assign io.out_valid  = valid_q;
  assign io.out_prod   = acc_q;
  assign io.out_cycles = cycles_q;
  always_comb begin
    state_d  = accept ? BUSY : busy && last ? DONE : state_q == DONE && io.out_ready ? IDLE : state_q;
    a_d      = accept ? io.in_a : a_q;
    b_d      = accept ? io.in_b : b_q;
    approx_d = accept ? io.in_approx : approx_q;
    acc_d    = accept ? '0 : busy ? acc_q + pp : acc_q;
    k_d      = accept ? '0 : busy && !last ? k_q + 1'b1 : k_q;
    cycles_d = busy && last ? k_q + 1'b1 : cycles_q;
    valid_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      cycles_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      cycles_q <= cycles_d;
      valid_q  <= valid_d;
    end
  end
endmodule

// File: doc/seq_approx_mul.md
Name: seq_approx_mul

Overview:
Iterative shift-and-add unsigned multiplier with per-operation selectable approximation. It generalises the fixed 2x2 approximate multiplier block to a parametrised width, a configurable truncation depth and optional early exit. It adds a valid/ready handshake on both sides. It sits between operand producers and accumulation or error-evaluation logic that want a small-area multiplier with a bounded, known error.

Parameters:
WIDTH, 4, operand width in bits (2..16)
TRUNC_COLS, 2, partial-product columns 0..TRUNC_COLS-1 forced to 0 in approx mode (0..2*WIDTH-1)
EARLY_EXIT, 1, 1 = stop iterating once the remaining multiplier bits are all zero
CNT_W, clog2(WIDTH+1), width of the out_cycles field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept operands
in_a  in  WIDTH  multiplicand, unsigned
in_b  in  WIDTH  multiplier, unsigned
in_approx  in  1  1 = truncated (approximate) product, 0 = exact product
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_prod  out  2*WIDTH  product
out_cycles  out  CNT_W  number of BUSY iterations used for this result

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1 after reset release (0 while rst_n=0), out_valid=0, out_prod=0, out_cycles=0, internal accumulator/operand registers=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1 (combinational from state).
  - Accept on in_valid&in_ready: latch a, b and approx; clear acc; k=0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle handles multiplier bit k: if b[k]=1, acc += (a<<k) & M.
  - M = ~((1<<TRUNC_COLS)-1) when approx=1; M = all ones when approx=0.
  - Accumulator is 2*WIDTH bits; the sum cannot overflow.
  - Go to DONE when k==WIDTH-1, or when EARLY_EXIT=1 and b[WIDTH-1:k+1]==0. Otherwise k++.
  - BUSY always lasts at least 1 cycle, so b=0 gives out_cycles=1.
- DONE:
  - out_valid=1.
  - out_prod=acc and out_cycles=k+1; both are held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE and drop out_valid.
  - No new operand is accepted in the same cycle; the earliest next accept is the following cycle.
- Latency: accept edge at cycle t gives out_valid high at cycle t+out_cycles+1.
  - Throughput: one operation per out_cycles+2 cycles when out_ready is held at 1.
- Result definition (reference model): out_prod = sum over i of b[i] ? ((a<<i) & M) : 0.
  - approx=0: exact a*b.
  - approx=1: error = exact - out_prod, with 0 <= error <= WIDTH*(2^TRUNC_COLS - 1). Error is never negative.
- TRUNC_COLS=0: both modes are exact.
- in_a, in_b and in_approx are ignored except at accept. Changes during BUSY or DONE have no effect.
- in_valid in BUSY or DONE is not accepted; the source must hold it until in_ready=1.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- out_ready high while out_valid=0: no effect.

Test Plan:
- WIDTH=4, TRUNC_COLS=2, EARLY_EXIT=1; a=15, b=15, approx=0 -> out_prod=225, out_cycles=4, out_valid 5 cycles after accept.
- Same operands, approx=1 -> partial products 12+28+60+120, out_prod=220, error=5 (≤12), out_cycles=4.
- a=7, b=1, approx=0 -> out_prod=7, out_cycles=1. Then b=0 -> out_prod=0, out_cycles=1. With EARLY_EXIT=0, both cases give out_cycles=4.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> out_prod and out_cycles stable, in_ready=0 throughout. Assert out_ready -> in_ready=1 the next cycle.
- Reset mid-op: deassert rst_n during the 2nd BUSY cycle -> out_valid=0 and out_prod=0 immediately. After release, in_ready=1 and the next operation (a=3, b=5, exact) gives 15.
- Random sweep: all 256 operand pairs × both modes against the reference model, with random in_valid/out_ready gaps -> zero mismatches and every error within the bound.
